// File: rtl/somador4_sync.sv
// somador4_sync: registered WIDTH-bit ripple-carry adder with carry in/out,
// two's-complement overflow flag and a one-cycle valid qualifier.
module somador4_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_valid,
    output logic             saida1,
    output logic [WIDTH-1:0] saida2,
    output logic             overflow,
    output logic             out_valid
);

    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] s;

    logic             saida1_d,    saida1_q;
    logic [WIDTH-1:0] saida2_d,    saida2_q;
    logic             overflow_d,  overflow_q;
    logic             out_valid_d, out_valid_q;

    // Ripple chain of full-adder cells, k[i] is the carry into bit i
    always_comb begin
        k    = '0;
        s    = '0;
        k[0] = c;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ k[i];
            k[i+1] = (a[i] & b[i]) | (k[i] & (a[i] ^ b[i]));
        end
    end

    // Next-state: load a new result when in_valid, otherwise hold (inputs ignored, so X cannot leak)
    always_comb begin
        saida1_d    = saida1_q;
        saida2_d    = saida2_q;
        overflow_d  = overflow_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            saida1_d   = k[WIDTH];
            saida2_d   = s;
            overflow_d = k[WIDTH-1] ^ k[WIDTH];
        end
    end

    // Output register; synchronous reset wins over in_valid and discards that cycle's operand
    always_ff @(posedge clk) begin
        if (reset) begin
            saida1_q    <= 1'b0;
            saida2_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            saida1_q    <= saida1_d;
            saida2_q    <= saida2_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign saida1    = saida1_q;
    assign saida2    = saida2_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_somador4_sync.sv
// tb_somador4_sync: table-driven and exhaustive checks of somador4_sync with a
// scoreboard queue of expected results.
module tb_somador4_sync;

    logic       clk;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic       in_valid;
    logic       saida1;
    logic [3:0] saida2;
    logic       overflow;
    logic       out_valid;

    typedef struct packed {
        logic       s1;
        logic [3:0] s2;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        exp_t       e;
    } vec_t;

    exp_t q[$];
    exp_t last;
    int   checks;
    int   errors;

    somador4_sync #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .c         (c),
        .in_valid  (in_valid),
        .saida1    (saida1),
        .saida2    (saida2),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer sum plus signed-overflow rule (same-sign operands, different-sign result)
    function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb_, input logic tc);
        logic [4:0] sum;
        exp_t       r;
        sum   = {1'b0, ta} + {1'b0, tb_} + {4'b0, tc};
        r.s1  = sum[4];
        r.s2  = sum[3:0];
        r.ovf = (ta[3] == tb_[3]) && (sum[3] != ta[3]);
        return r;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic check_res(input string name, input exp_t want);
        exp_t got;
        got = {saida1, saida2, overflow};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got s1=%b s2=%b ovf=%b want s1=%b s2=%b ovf=%b",
                     name, got.s1, got.s2, got.ovf, want.s1, want.s2, want.ovf);
        end
    endtask

    // One clock: drive inputs, push expected result if accepted, compare 1 ns after the edge
    task automatic step(input string name, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tc, input logic tv, input logic tr, input exp_t e);
        logic exp_v;
        exp_t want;
        a        = ta;
        b        = tb_;
        c        = tc;
        in_valid = tv;
        reset    = tr;
        exp_v    = tv && !tr;
        if (exp_v) q.push_back(e);
        @(posedge clk);
        #1;
        if (tr) begin
            last = '0;
            q.delete();
        end
        check_bit({name, ".out_valid"}, out_valid, exp_v);
        if (exp_v && q.size() > 0) begin
            want = q.pop_front();
            last = want;
            check_res({name, ".result"}, want);
        end else begin
            check_res({name, ".hold"}, last);
        end
    endtask

    task automatic idle(input string name);
        step(name, 4'bxxxx, 4'bxxxx, 1'bx, 1'b0, 1'b0, '0);
    endtask

    vec_t vecs[4];

    initial begin
        checks   = 0;
        errors   = 0;
        last     = '0;
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c        = 1'b0;

        vecs[0] = '{a: 4'b0000, b: 4'b0000, c: 1'b0, e: '{s1: 1'b0, s2: 4'b0000, ovf: 1'b0}};
        vecs[1] = '{a: 4'b1111, b: 4'b1111, c: 1'b1, e: '{s1: 1'b1, s2: 4'b1111, ovf: 1'b0}};
        vecs[2] = '{a: 4'b1001, b: 4'b0110, c: 1'b1, e: '{s1: 1'b1, s2: 4'b0000, ovf: 1'b0}};
        vecs[3] = '{a: 4'b0111, b: 4'b0001, c: 1'b0, e: '{s1: 1'b0, s2: 4'b1000, ovf: 1'b1}};

        // Reset held two cycles, with operands and in_valid that must be discarded
        step("reset0", 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b1, '0);
        step("reset1", 4'b0101, 4'b0101, 1'b1, 1'b1, 1'b1, '0);
        idle("post_reset");

        // Directed vectors back-to-back, then hold with X inputs
        for (int i = 0; i < 4; i++)
            step($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b1, 1'b0, vecs[i].e);
        idle("hold0");
        idle("hold1");

        // Accept one operand, then reset with in_valid high: no result for the reset-cycle operand
        step("pre_rst", 4'b0011, 4'b0100, 1'b0, 1'b1, 1'b0, '{s1: 1'b0, s2: 4'b0111, ovf: 1'b0});
        step("mid_rst", 4'b1111, 4'b1111, 1'b1, 1'b1, 1'b1, '0);
        idle("after_rst");

        // Exhaustive back-to-back sweep of {a,b,c}
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            step("exh", v[8:5], v[4:1], v[0], 1'b1, 1'b0, model(v[8:5], v[4:1], v[0]));
        end
        idle("drain");

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
